serial_parity_xor: RTL
======================

# serial_parity_xor

Bit-serial, parametrised parity engine that extends the lab's mux-built XOR gate to W-bit words, with an even/odd mode and a valid/ready input handshake. Each accepted word is shifted out LSB-first, one bit per clock, and folded into a 1-bit accumulator. Every XOR step is built from an instance of the team's 2:1 `mux` cell, with wires and constants only. It sits between a word source and a consumer that needs a registered parity bit with a one-cycle valid strobe.

## Interface
- `W`, default 8: data width in bits; legal range W >= 1.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: source has a word on `in_data`.
- `in_ready` output 1: block can accept a word; derived combinationally from state.
- `in_data` input W: word to be reduced.
- `in_odd` input 1: 0 selects even parity (initial accumulator 0); 1 selects odd parity (initial accumulator 1). Sampled only on acceptance.
- `in_chain` input 1: present only when `SERIAL_PARITY_ACCUM_EN` is defined (see Configuration).
- `out_valid` output 1: one-cycle strobe marking `out_parity` as new.
- `out_parity` output 1: registered result; holds its value until the next result.

## Operation
- Acceptance: a word is accepted on a rising edge where `in_valid && in_ready`. No other edge captures `in_data`.
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: `in_ready`=0.
  - DONE: `in_ready`=1, `out_valid`=1.
- On acceptance:
  - `shreg` <= `in_data`.
  - `acc` <= `in_odd`.
  - `cnt` <= W-1.
  - Next state is SHIFT.
- In SHIFT, on each edge:
  - `acc` <= mux(sel=`shreg[0]`, d0=`acc`, d1=~`acc`).
  - `shreg` <= `shreg` >> 1.
  - If `cnt`==0, `out_parity` <= the new `acc` and the state goes to DONE; otherwise `cnt` <= `cnt`-1.
- The ~`acc` in the update is also produced by a `mux` instance (d0=1, d1=0). No `^` operator is used in the datapath.
- `cnt` width is max(1, $clog2(W)). For W=1, SHIFT lasts exactly one edge.
- DONE:
  - With an acceptance on that edge, the next state is SHIFT (back-to-back).
  - Otherwise the next state is IDLE.
- Inputs arriving while in SHIFT are ignored; the source must hold `in_valid` and `in_data` until acceptance.
- Result definition: `out_parity` = `in_odd` XOR (reduction XOR of `in_data`).

## Timing
- Values during and after reset:
  - State is IDLE.
  - `in_ready`=1.
  - `out_valid`=0.
  - `out_parity`=0.
  - `shreg`, `acc`, `cnt` are 0.
- No acceptance occurs while `reset` is high.
- Latency: a word accepted at edge N gives `out_valid`=1 and a valid `out_parity` in the cycle after edge N+W, through edge N+W+1.
- Throughput: one word per W+1 cycles when `in_valid` is held high.
- `in_ready` is low for exactly W cycles after each acceptance.
- `out_valid` is never high for two consecutive cycles.
- Reset mid-operation: state is abandoned immediately and no `out_valid` is produced for the in-flight word. `out_parity` is forced to 0.

## Configuration
- Macro `SERIAL_PARITY_ACCUM_EN`.
- Defined:
  - Port `in_chain` exists.
  - On acceptance with `in_chain`=1, `acc` <= current `out_parity` and `in_odd` is ignored. This gives a running parity across multiple words.
  - With `in_chain`=0, behaviour is as without the macro.
  - After reset, a chained word starts from 0.
- Not defined: no `in_chain` port; `acc` always starts from `in_odd`.

## Test plan
- Reset with no stimulus, W=8: `in_ready`=1, `out_valid`=0, `out_parity`=0 during and after reset.
- W=8, `in_data`=8'hA5, `in_odd`=0, accepted at edge 0 -> `out_valid` high only in the cycle after edge 8, `out_parity`=0. Repeat with `in_data`=8'h07 -> 1, and 8'h07 with `in_odd`=1 -> 0.
- `in_valid` held high with 8'hFF then 8'h01 (even parity), second word presented during SHIFT:
  - Second word accepted on the DONE-cycle edge (edge 9).
  - Results 0 then 1, with `out_valid` pulses 9 cycles apart.
  - `in_ready` low for 8 cycles after each accept.
- `reset` asserted for one cycle 4 edges into SHIFT -> no `out_valid` pulse, `out_parity`=0. Next word 8'h80 afterwards -> `out_parity`=1.
- `SERIAL_PARITY_ACCUM_EN` defined, sequence of words:
  - 8'h01 with `in_chain`=0 -> 1.
  - 8'h00 with `in_chain`=1 -> 1.
  - 8'h03 with `in_chain`=1 -> 1.
  - 8'h00 with `in_chain`=0, `in_odd`=0 -> 0.
- W=1: `in_data`=1'b1, `in_odd`=0 -> `out_valid` in the cycle after edge 1, `out_parity`=1. Sweep all four {`in_data`,`in_odd`} pairs, expecting `out_parity` = `in_data` XOR `in_odd`.

Source files
------------

// File: rtl/serial_parity_xor.sv
// serial_parity_xor: bit-serial parity reduction of a W-bit word.
// Each accepted word is shifted out LSB-first, one bit per clock. Each bit
// is folded into a 1-bit accumulator through 2:1 mux cells only.
//
// Optional feature macro: SERIAL_PARITY_ACCUM_EN adds the in_chain port.
// With in_chain=1, the accumulator is seeded from the previous result.
// This gives a running parity across several words.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   source presents a word
//   in_ready   out  block can accept a word (decoded from state)
//   in_data    in   W-bit word to reduce
//   in_odd     in   0 = even parity seed, 1 = odd parity seed
//   in_chain   in   (SERIAL_PARITY_ACCUM_EN only) seed from out_parity
//   out_valid  out  one-cycle strobe; out_parity is new
//   out_parity out  registered parity result, held until the next result

// 2:1 mux cell: y = sel ? d1 : d0
module mux (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module serial_parity_xor #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_odd,
`ifdef SERIAL_PARITY_ACCUM_EN
    input  logic         in_chain,
`endif
    output logic         out_valid,
    output logic         out_parity
);
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    shreg;
    logic [W-1:0]    shreg_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            acc;
    logic            acc_nxt;
    logic            parity_nxt;
    logic            acc_inv;
    logic            acc_step;
    logic            acc_init;
    logic            accept;

    // Inverter built from a mux: sel=acc picks constant 0 when acc=1, and 1 otherwise
    mux u_inv (
        .sel (acc),
        .d0  (1'b1),
        .d1  (1'b0),
        .y   (acc_inv)
    );

    // XOR step: toggle the accumulator when the current LSB is 1
    mux u_step (
        .sel (shreg[0]),
        .d0  (acc),
        .d1  (acc_inv),
        .y   (acc_step)
    );

    // Accumulator seed on acceptance
`ifdef SERIAL_PARITY_ACCUM_EN
    assign acc_init = in_chain ? out_parity : in_odd;
`else
    assign acc_init = in_odd;
`endif

    assign in_ready  = (state != SHIFT);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            acc        <= 1'b0;
            out_parity <= 1'b0;
        end else begin
            state      <= state_nxt;
            shreg      <= shreg_nxt;
            cnt        <= cnt_nxt;
            acc        <= acc_nxt;
            out_parity <= parity_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        cnt_nxt    = cnt;
        acc_nxt    = acc;
        parity_nxt = out_parity;

        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    shreg_nxt = in_data;
                    acc_nxt   = acc_init;
                    cnt_nxt   = CW'(W - 1);
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                acc_nxt   = acc_step;
                shreg_nxt = shreg >> 1;
                if (cnt == '0) begin
                    parity_nxt = acc_step;
                    state_nxt  = DONE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
